// File: rtl/led_event_scheduler_pkg.sv
// Shared definitions for the LED event scheduler: colours, FSM states and
// fault location encodings.
package led_pkg;

  // LED colours as {R,G,B}
  localparam logic [2:0] COLOR_OFF   = 3'b000;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_RED   = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    FAULT,
    NODE,
    DONE_WAIT,
    DONE
  } led_state_t;

  // fault_pos encodings
  localparam logic [1:0] POS_ALL  = 2'd0;
  localparam logic [1:0] POS_LED1 = 2'd1;
  localparam logic [1:0] POS_LED2 = 2'd2;
  localparam logic [1:0] POS_LED3 = 2'd3;

  // True when the LED at position idx is selected by a fault location
  function automatic logic led_selected(input logic [1:0] pos, input logic [1:0] idx);
    return (pos == POS_ALL) || (pos == idx);
  endfunction

endpackage

// File: rtl/led_event_scheduler_timer.sv
// Loadable down-counter that saturates at zero; zero flags expiry.
module led_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/led_event_scheduler.sv
// Owns the three RGB status LEDs: arbitrates fault, node-arrival and
// end-of-run requests with minimum display times and strict priority
// (fault > final node > plain node). Outputs are registered from the
// state, so the LEDs trail a state change by one clock.
// Optional feature macro: LED_BLINK_EN (fault LEDs blink instead of solid).
module led_event_scheduler
  import led_pkg::*;
#(
  parameter int NODE_W         = 6,
  parameter int END_NODE       = 13,
  parameter int NODE_FLASH_CYC = 25_000_000,
  parameter int FAULT_HOLD_CYC = 50_000_000,
  parameter int DONE_DELAY_CYC = 50_000_000,
  parameter int BLINK_HALF_CYC = 12_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fault_req,
  input  logic [1:0]        fault_pos,
  input  logic              node_pulse,
  input  logic [NODE_W-1:0] node_counter,
  output logic              fault_ack,
  output logic              busy,
  output logic [2:0]        rgb_led_1,
  output logic [2:0]        rgb_led_2,
  output logic [2:0]        rgb_led_3
);

  localparam int MAX_A   = (NODE_FLASH_CYC > FAULT_HOLD_CYC) ? NODE_FLASH_CYC : FAULT_HOLD_CYC;
  localparam int MAX_B   = (DONE_DELAY_CYC > BLINK_HALF_CYC) ? DONE_DELAY_CYC : BLINK_HALF_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] LOAD_NODE  = TW'(NODE_FLASH_CYC - 1);
  localparam logic [TW-1:0] LOAD_FAULT = TW'(FAULT_HOLD_CYC - 1);
  localparam logic [TW-1:0] LOAD_DONE  = TW'(DONE_DELAY_CYC - 1);

  led_state_t    state, next_state;
  logic          pending_node, pending_done;
  logic          next_pending_node, next_pending_done;
  logic          fault_entry, entry_q;
  logic [1:0]    pos_q;
  logic          load;
  logic [TW-1:0] load_val;
  logic          tzero;
  logic          final_pulse, plain_pulse;
  logic          fault_on;
  logic [2:0]    led1_n, led2_n, led3_n;

  assign final_pulse = node_pulse && (node_counter == NODE_W'(END_NODE));
  assign plain_pulse = node_pulse && !final_pulse;

  led_timer #(.W(TW)) u_main_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (tzero)
  );

`ifdef LED_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF_CYC + 1);
  logic blink_zero;
  logic blink_load;
  logic blink_phase;

  // Blink period restarts on every fault entry and rolls over while in FAULT
  assign blink_load = fault_entry || ((state == FAULT) && blink_zero);

  led_timer #(.W(BW)) u_blink_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (blink_load),
    .load_val (BW'(BLINK_HALF_CYC - 1)),
    .zero     (blink_zero)
  );

  assign fault_on = !blink_phase;
`else
  assign fault_on = 1'b1;
`endif

  // Next-state, timer load and pending-request bookkeeping
  always_comb begin
    next_state        = state;
    load              = 1'b0;
    load_val          = '0;
    fault_entry       = 1'b0;
    next_pending_node = pending_node;
    next_pending_done = pending_done;
    case (state)
      IDLE: begin
        if (fault_req) begin
          next_state        = FAULT;
          load              = 1'b1;
          load_val          = LOAD_FAULT;
          fault_entry       = 1'b1;
          next_pending_node = pending_node | plain_pulse;
          next_pending_done = pending_done | final_pulse;
        end else if (final_pulse) begin
          next_state = DONE_WAIT;
          load       = 1'b1;
          load_val   = LOAD_DONE;
        end else if (plain_pulse) begin
          next_state = NODE;
          load       = 1'b1;
          load_val   = LOAD_NODE;
        end
      end
      FAULT: begin
        // A pulse arriving in the exit cycle is treated as already pended
        if (tzero && !fault_req) begin
          if (pending_done || final_pulse) begin
            next_state = DONE_WAIT;
            load       = 1'b1;
            load_val   = LOAD_DONE;
          end else if (pending_node || plain_pulse) begin
            next_state = NODE;
            load       = 1'b1;
            load_val   = LOAD_NODE;
          end else begin
            next_state = IDLE;
          end
          next_pending_node = 1'b0;
          next_pending_done = 1'b0;
        end else begin
          next_pending_node = pending_node | plain_pulse;
          next_pending_done = pending_done | final_pulse;
        end
      end
      NODE: begin
        if (fault_req) begin
          // The running flash is dropped; only a fresh pulse is pended
          next_state        = FAULT;
          load              = 1'b1;
          load_val          = LOAD_FAULT;
          fault_entry       = 1'b1;
          next_pending_node = pending_node | plain_pulse;
          next_pending_done = pending_done | final_pulse;
        end else if (final_pulse) begin
          next_state = DONE_WAIT;
          load       = 1'b1;
          load_val   = LOAD_DONE;
        end else if (plain_pulse) begin
          load     = 1'b1;
          load_val = LOAD_NODE;
        end else if (tzero) begin
          next_state = IDLE;
        end
      end
      DONE_WAIT: begin
        if (fault_req) begin
          next_state        = FAULT;
          load              = 1'b1;
          load_val          = LOAD_FAULT;
          fault_entry       = 1'b1;
          next_pending_done = 1'b1;
        end else if (tzero) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = DONE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // LED colour decode from the current state
  always_comb begin
    led1_n = COLOR_OFF;
    led2_n = COLOR_OFF;
    led3_n = COLOR_OFF;
    case (state)
      NODE: begin
        led1_n = COLOR_RED;
        led2_n = COLOR_RED;
        led3_n = COLOR_RED;
      end
      DONE: begin
        led1_n = COLOR_GREEN;
        led2_n = COLOR_GREEN;
        led3_n = COLOR_GREEN;
      end
      FAULT: begin
        if (fault_on && led_selected(pos_q, POS_LED1)) led1_n = COLOR_BLUE;
        if (fault_on && led_selected(pos_q, POS_LED2)) led2_n = COLOR_BLUE;
        if (fault_on && led_selected(pos_q, POS_LED3)) led3_n = COLOR_BLUE;
      end
      default: begin
        led1_n = COLOR_OFF;
      end
    endcase
  end

  // State, pending flags and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pending_node <= 1'b0;
      pending_done <= 1'b0;
      entry_q      <= 1'b0;
      pos_q        <= POS_ALL;
      fault_ack    <= 1'b0;
      busy         <= 1'b0;
      rgb_led_1    <= COLOR_OFF;
      rgb_led_2    <= COLOR_OFF;
      rgb_led_3    <= COLOR_OFF;
`ifdef LED_BLINK_EN
      blink_phase  <= 1'b0;
`endif
    end else begin
      state        <= next_state;
      pending_node <= next_pending_node;
      pending_done <= next_pending_done;
      entry_q      <= fault_entry;
      pos_q        <= fault_pos;
      fault_ack    <= entry_q;
      busy         <= (state != IDLE);
      rgb_led_1    <= led1_n;
      rgb_led_2    <= led2_n;
      rgb_led_3    <= led3_n;
`ifdef LED_BLINK_EN
      if (fault_entry) begin
        blink_phase <= 1'b0;
      end else if ((state == FAULT) && blink_zero) begin
        blink_phase <= ~blink_phase;
      end
`endif
    end
  end

endmodule

// File: tb/tb_led_event_scheduler.sv
// Bench for led_event_scheduler with short timing parameters.
// Outputs are packed as {led1, led2, led3, busy, fault_ack}.
module tb_led_event_scheduler;

  localparam logic [2:0] O = 3'b000;
  localparam logic [2:0] B = 3'b001;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fault_req = 1'b0;
  logic [1:0] fault_pos = 2'd0;
  logic       node_pulse = 1'b0;
  logic [5:0] node_counter = 6'd0;
  logic       fault_ack, busy;
  logic [2:0] rgb_led_1, rgb_led_2, rgb_led_3;

  typedef struct {
    logic       fr;
    logic [1:0] fp;
    logic       np;
    logic [5:0] nc;
    logic [10:0] ex;
    logic       bf;  // fault cycle in the dark half of a blink period
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  led_event_scheduler #(
    .NODE_W(6), .END_NODE(13), .NODE_FLASH_CYC(4), .FAULT_HOLD_CYC(6),
    .DONE_DELAY_CYC(5), .BLINK_HALF_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .fault_req(fault_req), .fault_pos(fault_pos),
    .node_pulse(node_pulse), .node_counter(node_counter), .fault_ack(fault_ack),
    .busy(busy), .rgb_led_1(rgb_led_1), .rgb_led_2(rgb_led_2), .rgb_led_3(rgb_led_3)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] outs_now();
    return {rgb_led_1, rgb_led_2, rgb_led_3, busy, fault_ack};
  endfunction

  task automatic check_val(input string name, input logic [10:0] act, input logic [10:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %b_%b_%b busy=%b ack=%b, want %b_%b_%b busy=%b ack=%b",
               name, act[10:8], act[7:5], act[4:2], act[1], act[0],
               e[10:8], e[7:5], e[4:2], e[1], e[0]);
    end
  endtask

  task automatic check_one();
    logic [10:0] e;
    e = exp_q.pop_front();
    check_val($sformatf("vec@%0t", $time), outs_now(), e);
  endtask

  // Driver: one record per cycle; its expectation is compared two negedges later
  task automatic step(input logic fr, input logic [1:0] fp, input logic np,
                      input logic [5:0] nc, input logic [10:0] ex, input logic bf);
    logic [10:0] e;
    @(negedge clk);
    if (exp_q.size() == 2) check_one();
    fault_req    = fr;
    fault_pos    = fp;
    node_pulse   = np;
    node_counter = nc;
    e = ex;
`ifdef LED_BLINK_EN
    if (bf) e[10:2] = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic drain();
    if (exp_q.size() != 0) begin
      @(negedge clk);
      check_one();
    end
    fault_req  = 1'b0;
    node_pulse = 1'b0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      check_one();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fault_req  = 1'b0;
    node_pulse = 1'b0;
    @(negedge clk);
    check_val("reset_state", outs_now(), 11'd0);
    rst = 1'b0;
  endtask

  function automatic logic [10:0] ex(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] c, input logic bs, input logic ack);
    return {a, b, c, bs, ack};
  endfunction

  task automatic add(input logic fr, input logic [1:0] fp, input logic np, input logic [5:0] nc,
                     input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                     input logic bs, input logic ack, input logic bf);
    vec_t v;
    v.fr = fr; v.fp = fp; v.np = np; v.nc = nc; v.ex = ex(a, b, c, bs, ack); v.bf = bf;
    vecs.push_back(v);
  endtask

  task automatic hold(input int n, input logic fr, input logic [1:0] fp,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic bs);
    for (int i = 0; i < n; i++) step(fr, fp, 1'b0, 6'd0, ex(a, b, c, bs, 1'b0), 1'b0);
  endtask

  initial begin
    // Plain node flash: 4 cycles of red
    add(0,0,1,3, R,R,R,1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0, R,R,R,1,0,0);
    add(0,0,0,0, O,O,O,0,0,0);
    add(0,0,0,0, O,O,O,0,0,0);
    // Retrigger extends the flash
    add(0,0,1,7, R,R,R,1,0,0);
    add(0,0,0,0, R,R,R,1,0,0);
    add(0,0,1,2, R,R,R,1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0, R,R,R,1,0,0);
    add(0,0,0,0, O,O,O,0,0,0);
    // Short fault on led 2 holds for the minimum 6 cycles
    add(1,2,0,0, O,B,O,1,1,0);
    add(1,2,0,0, O,B,O,1,0,0);
    add(0,2,0,0, O,B,O,1,0,1);
    add(0,2,0,0, O,B,O,1,0,1);
    add(0,2,0,0, O,B,O,1,0,0);
    add(0,2,0,0, O,B,O,1,0,0);
    add(0,2,0,0, O,O,O,0,0,0);
    // Long fault, node pulse pended, replayed after exit
    add(1,0,0,0, B,B,B,1,1,0);
    add(1,0,0,0, B,B,B,1,0,0);
    add(1,0,1,5, B,B,B,1,0,1);
    add(1,0,0,0, B,B,B,1,0,1);
    add(1,0,0,0, B,B,B,1,0,0);
    add(1,0,0,0, B,B,B,1,0,0);
    add(1,0,0,0, B,B,B,1,0,1);
    add(1,0,0,0, B,B,B,1,0,1);
    for (int i = 0; i < 4; i++) add(0,0,0,0, R,R,R,1,0,0);
    add(0,0,0,0, O,O,O,0,0,0);
    // Fault preempts a flash; flash is discarded
    add(0,0,1,1, R,R,R,1,0,0);
    add(0,0,0,0, R,R,R,1,0,0);
    add(1,1,0,0, B,O,O,1,1,0);
    add(0,1,0,0, B,O,O,1,0,0);
    add(0,1,0,0, B,O,O,1,0,1);
    add(0,1,0,0, B,O,O,1,0,1);
    add(0,1,0,0, B,O,O,1,0,0);
    add(0,1,0,0, B,O,O,1,0,0);
    add(0,1,0,0, O,O,O,0,0,0);
    // Final node: 5 dark cycles, then terminal green
    add(0,0,1,13, O,O,O,1,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0, O,O,O,1,0,0);
    add(0,0,0,0, G,G,G,1,0,0);
    add(1,0,0,0, G,G,G,1,0,0);
    add(0,0,1,3, G,G,G,1,0,0);
    add(0,0,1,13, G,G,G,1,0,0);
    add(0,0,0,0, G,G,G,1,0,0);

    do_reset();
    foreach (vecs[i]) step(vecs[i].fr, vecs[i].fp, vecs[i].np, vecs[i].nc, vecs[i].ex, vecs[i].bf);
    drain();

    // Asynchronous reset in the middle of a flash
    do_reset();
    step(0,0,1,3, ex(R,R,R,1,0), 0);
    step(0,0,0,0, ex(R,R,R,1,0), 0);
    drain();
    check_val("pre_rst_red", outs_now(), ex(R,R,R,1,0));
    #2 rst = 1'b1;
    #1 check_val("async_rst", outs_now(), 11'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(3, 0, 0, O,O,O,0);
    drain();

    // Fault and final node together in IDLE: fault first, then done sequence
    step(1,3,1,13, ex(O,O,B,1,1), 0);
    step(0,3,0,0, ex(O,O,B,1,0), 0);
    step(0,3,0,0, ex(O,O,B,1,0), 1);
    step(0,3,0,0, ex(O,O,B,1,0), 1);
    step(0,3,0,0, ex(O,O,B,1,0), 0);
    step(0,3,0,0, ex(O,O,B,1,0), 0);
    step(0,3,0,0, ex(O,O,O,1,0), 0);
    step(0,3,1,2, ex(O,O,O,1,0), 0);
    hold(3, 0, 3, O,O,O,1);
    hold(2, 0, 3, G,G,G,1);
    drain();

    // Fault during the dark gap: fault shown, then gap restarts, then green
    do_reset();
    step(0,0,1,13, ex(O,O,O,1,0), 0);
    step(0,0,0,0, ex(O,O,O,1,0), 0);
    step(1,0,0,0, ex(B,B,B,1,1), 0);
    step(0,0,0,0, ex(B,B,B,1,0), 0);
    step(0,0,0,0, ex(B,B,B,1,0), 1);
    step(0,0,0,0, ex(B,B,B,1,0), 1);
    step(0,0,0,0, ex(B,B,B,1,0), 0);
    step(0,0,0,0, ex(B,B,B,1,0), 0);
    hold(5, 0, 0, O,O,O,1);
    hold(2, 0, 0, G,G,G,1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
